// File: rtl/aes_gf_pkg.sv
// Shared GF(2^8) helpers and types for the AES InvMixColumns engine.
package aes_gf_pkg;

    // Reduction constant for x^8 = x^4 + x^3 + x + 1.
    localparam logic [7:0] AES_POLY = 8'h1B;

    typedef logic [7:0] byte_t;

    // Element [3] is s0, the most significant byte of the packed column.
    typedef byte_t [3:0] column_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    // Multiply by x in GF(2^8).
    function automatic byte_t xtime(input byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY : 8'h00);
    endfunction

endpackage

// File: rtl/inv_mix_column_comb.sv
// Combinational InvMixColumns for a single 32-bit column (s0 in bits [31:24]).
module inv_mix_column_comb
    import aes_gf_pkg::*;
(
    input  logic [31:0] col_in,
    output logic [31:0] col_out
);

    column_t s;
    byte_t   x2 [4];
    byte_t   x4 [4];
    byte_t   x8 [4];
    byte_t   m9 [4];
    byte_t   mb [4];
    byte_t   md [4];
    byte_t   me [4];

    assign s = column_t'(col_in);

    // Per-byte multiples 9, B, D, E built from an xtime chain.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            x2[i] = xtime(s[3-i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ s[3-i];
            mb[i] = x8[i] ^ x2[i] ^ s[3-i];
            md[i] = x8[i] ^ x4[i] ^ s[3-i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
    end

    // Circulant matrix rows {E,B,D,9} rotated once per output byte.
    always_comb begin
        col_out = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                   m9[0] ^ me[1] ^ mb[2] ^ md[3],
                   md[0] ^ m9[1] ^ me[2] ^ mb[3],
                   mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Iterative InvMixColumns engine: COLS_PER_CYCLE columns per RUN cycle, valid/ready in and out.
module inv_mix_columns_seq
    import aes_gf_pkg::*;
#(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] state_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] state_out,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cfg
        $error("inv_mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    // col_cnt value of the final group; with 4 columns per cycle this is 0.
    localparam logic [1:0] LAST_GROUP = 2'(4 - COLS_PER_CYCLE);
    // Counter step; wraps to 0 for 4 columns per cycle, which is harmless since N=1.
    localparam logic [1:0] STEP       = 2'(COLS_PER_CYCLE);

    state_e       state_q;
    logic [1:0]   col_cnt_q;
    logic [127:0] work_q;
    logic         out_valid_q;
    logic         busy_q;

    logic [31:0]  grp_in  [COLS_PER_CYCLE];
    logic [31:0]  grp_out [COLS_PER_CYCLE];
    logic [127:0] work_run;
    logic         last_group;

    assign last_group = (col_cnt_q == LAST_GROUP);

    // Pick the column group addressed by col_cnt out of the work register.
    always_comb begin
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            grp_in[j] = work_q[127 - 32 * (int'(col_cnt_q) + j) -: 32];
        end
    end

    for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
        inv_mix_column_comb u_col (
            .col_in  (grp_in[g]),
            .col_out (grp_out[g])
        );
    end

    // Write the transformed group back in place, leaving other columns untouched.
    always_comb begin
        work_run = work_q;
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
            work_run[127 - 32 * (int'(col_cnt_q) + j) -: 32] = grp_out[j];
        end
    end

    // Control FSM with registered out_valid/busy; reset discards any partial result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            col_cnt_q   <= '0;
            work_q      <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        work_q    <= state_in;
                        col_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= RUN;
                    end
                end
                RUN: begin
                    work_q    <= work_run;
                    col_cnt_q <= col_cnt_q + STEP;
                    if (last_group) begin
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        if (in_valid) begin
                            // Back-to-back: hand off and start the next state immediately.
                            work_q    <= state_in;
                            col_cnt_q <= '0;
                            state_q   <= RUN;
                        end else begin
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    busy_q      <= 1'b0;
                    col_cnt_q   <= '0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    // Ready is combinational from out_ready only, never from in_valid.
    always_comb begin
        in_ready = (state_q == IDLE) || ((state_q == DONE) && out_ready);
    end

    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign state_out = work_q;

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Bench for inv_mix_columns_seq: one DUT per legal COLS_PER_CYCLE, checked against a GF model.
module tb_inv_mix_columns_seq;

    logic         clk;
    logic         rst       [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic [127:0] state_in  [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [127:0] state_out [3];
    logic         busy      [3];

    int n_pass  = 0;
    int n_total = 0;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        inv_mix_columns_seq #(.COLS_PER_CYCLE(1 << g)) u_dut (
            .clk       (clk),
            .rst       (rst[g]),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .state_in  (state_in[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .state_out (state_out[g]),
            .busy      (busy[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;

    // Carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1.
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p = '0;
        logic [15:0] m = 16'h011B;
        for (int i = 0; i < 8; i++) if (b[i]) p ^= (16'(a) << i);
        for (int i = 14; i >= 8; i--) if (p[i]) p ^= (m << (i - 8));
        return p[7:0];
    endfunction

    // Column-wise matrix product with a circulant coefficient row.
    function automatic logic [127:0] mix(input logic [127:0] s, input bit inverse);
        logic [7:0]   base [4];
        logic [127:0] r = '0;
        logic [7:0]   acc;
        if (inverse) base = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
        else         base = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++) begin
            for (int row = 0; row < 4; row++) begin
                acc = '0;
                for (int j = 0; j < 4; j++)
                    acc ^= gmul(base[(j - row + 4) % 4], s[127 - 32 * c - 8 * j -: 8]);
                r[127 - 32 * c - 8 * row -: 8] = acc;
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One transaction from IDLE: accept, wait for the result, check latency and data, drain it.
    task automatic run_one(input int k, input string name, input logic [127:0] din,
                           input logic [127:0] exp);
        int cnt = 0;
        check($sformatf("%s idle_ready k%0d", name, k), 128'(in_ready[k]), 128'd1);
        in_valid[k] = 1'b1;
        state_in[k] = din;
        tick();
        in_valid[k] = 1'b0;
        state_in[k] = rnd128();
        check($sformatf("%s run_ready k%0d", name, k), 128'(in_ready[k]), 128'd0);
        check($sformatf("%s run_busy k%0d", name, k), 128'(busy[k]), 128'd1);
        while (!out_valid[k] && cnt < 20) begin
            tick();
            cnt++;
        end
        check($sformatf("%s latency k%0d", name, k), 128'(cnt), 128'(4 >> k));
        check($sformatf("%s data k%0d", name, k), state_out[k], exp);
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        check($sformatf("%s drained k%0d", name, k), 128'(out_valid[k]), 128'd0);
    endtask

    // Result held with out_ready low while state_in churns.
    task automatic hold_test(input int k, input vec_t v);
        int cnt = 0;
        in_valid[k] = 1'b1;
        state_in[k] = v.din;
        tick();
        in_valid[k] = 1'b0;
        while (!out_valid[k] && cnt < 20) begin
            tick();
            cnt++;
        end
        check($sformatf("hold first k%0d", k), state_out[k], v.dout);
        for (int i = 0; i < 10; i++) begin
            in_valid[k] = 1'b1;
            state_in[k] = rnd128();
            tick();
            check($sformatf("hold data k%0d c%0d", k, i), state_out[k], v.dout);
            check($sformatf("hold ready k%0d c%0d", k, i), 128'(in_ready[k]), 128'd0);
            check($sformatf("hold valid k%0d c%0d", k, i), 128'(out_valid[k]), 128'd1);
        end
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        tick();
        out_ready[k] = 1'b0;
        check($sformatf("hold released k%0d", k), 128'(out_valid[k]), 128'd0);
    endtask

    // Eight states with in_valid/out_ready pinned high: in order, one per N+1 cycles.
    task automatic stream(input int k);
        logic [127:0] st [8];
        int  sent = 0;
        int  recv = 0;
        int  cyc  = 0;
        int  last = 0;
        bit  acc;
        for (int i = 0; i < 8; i++) st[i] = {rnd128()} ^ 128'(i);
        out_ready[k] = 1'b1;
        while (recv < 8 && cyc < 200) begin
            if (sent < 8) begin
                in_valid[k] = 1'b1;
                state_in[k] = st[sent];
            end else begin
                in_valid[k] = 1'b0;
            end
            acc = in_valid[k] && in_ready[k];
            if (out_valid[k]) begin
                check($sformatf("stream data k%0d #%0d", k, recv), state_out[k], mix(st[recv], 1'b1));
                if (recv > 0)
                    check($sformatf("stream gap k%0d #%0d", k, recv), 128'(cyc - last),
                          128'((4 >> k) + 1));
                last = cyc;
                recv++;
            end
            tick();
            cyc++;
            if (acc) sent++;
        end
        check($sformatf("stream count k%0d", k), 128'(recv), 128'd8);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b0;
        tick();
    endtask

    // Reset one cycle into RUN (or into DONE when N=1), then recover.
    task automatic reset_mid(input int k, input vec_t v);
        in_valid[k] = 1'b1;
        state_in[k] = v.din;
        tick();
        in_valid[k] = 1'b0;
        tick();
        rst[k] = 1'b1;
        #1;
        check($sformatf("rst valid k%0d", k), 128'(out_valid[k]), 128'd0);
        check($sformatf("rst data k%0d", k), state_out[k], 128'd0);
        check($sformatf("rst busy k%0d", k), 128'(busy[k]), 128'd0);
        @(posedge clk);
        #1;
        rst[k] = 1'b0;
        tick();
        check($sformatf("rst ready k%0d", k), 128'(in_ready[k]), 128'd1);
        repeat (5) tick();
        check($sformatf("rst no_output k%0d", k), 128'(out_valid[k]), 128'd0);
        run_one(k, "after_rst", v.din, v.dout);
    endtask

    vec_t         tbl [3];
    logic [127:0] orig;

    initial begin
        tbl[0] = '{128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6,
                   128'hdb135345_f20a225c_01010101_c6c6c6c6};
        tbl[1] = '{128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff,
                   128'hd4d4d4d5_2d26314c_00000000_ffffffff};
        tbl[2] = '{128'hc6c6c6c6_01010101_8e4da1bc_9fdc589d,
                   128'hc6c6c6c6_01010101_db135345_f20a225c};

        for (int k = 0; k < 3; k++) begin
            rst[k]       = 1'b1;
            in_valid[k]  = 1'b0;
            out_ready[k] = 1'b0;
            state_in[k]  = '0;
        end
        repeat (2) tick();

        for (int k = 0; k < 3; k++) begin
            check($sformatf("reset valid k%0d", k), 128'(out_valid[k]), 128'd0);
            check($sformatf("reset data k%0d", k), state_out[k], 128'd0);
            check($sformatf("reset busy k%0d", k), 128'(busy[k]), 128'd0);
            check($sformatf("reset ready k%0d", k), 128'(in_ready[k]), 128'd1);
            rst[k] = 1'b0;
        end
        tick();

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < 3; i++)
                run_one(k, $sformatf("table%0d", i), tbl[i].din, tbl[i].dout);
            hold_test(k, tbl[1]);
            stream(k);
            reset_mid(k, tbl[0]);
            for (int i = 0; i < 1000; i++) begin
                orig = rnd128();
                run_one(k, "roundtrip", mix(orig, 1'b0), orig);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
